sample_framer: RTL and testbench

Collects the XADC oversampler's 16-bit sample stream (one-cycle `done` strobe per sample) into fixed-length frames and streams each completed frame out over a valid/ready handshake for the downstream FFT. It is the consumer end of the oversampler's sample/done interface. It uses two ping-pong frame buffers, so capture continues while the previous frame drains. Overruns are counted, never silently absorbed.

---
 rtl/sample_framer.sv | 169 ++++++++++++++++
 tb/tb_sample_framer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// sample_framer: packs the oversampler's sample/done stream into FRAME_LEN-word frames
// and streams them out through ping-pong buffers over a valid/ready handshake.
module sample_framer #(
    parameter int FRAME_LEN  = 1024,
    parameter int DATA_W     = 16,
    parameter int OFFSET_BIN = 1,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              overrun,
    output logic [15:0]       drop_count,
    input  logic              clear_overrun
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0] MSB_FLIP = (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    typedef enum logic {W_FILL, W_STALL} wr_state_t;

    wr_state_t         wr_state_reg;
    logic [IDX_W-1:0]  wptr_reg;
    logic              wbuf_reg;
    logic [1:0]        full_vec;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;

    logic [IDX_W-1:0]  fptr_reg;
    logic              fbuf_reg;
    logic              rbuf_reg;
    logic              q_valid_reg;
    logic              q_last_reg;
    logic              q_buf_reg;
    logic [IDX_W-1:0]  q_index_reg;
    logic [DATA_W-1:0] buf_q [2];

    logic              wr_en;
    logic              wr_wrap;
    logic              drop;
    logic              release_buf;
    logic              other_busy;
    logic              out_adv;
    logic              fetch;
    logic [DATA_W-1:0] wr_data;

    // Offset-binary conversion is folded into the write so the read side is a plain copy.
    assign wr_data     = in_sample ^ MSB_FLIP;
    assign wr_en       = in_done & ((wr_state_reg == W_FILL) | ~full_vec[wbuf_reg]);
    assign drop        = in_done & ~wr_en;
    assign wr_wrap     = wr_en & (wptr_reg == LAST_IDX);
    assign release_buf = out_valid & out_ready & out_last;
    // A buffer released on the same edge counts as free, so a completing frame never stalls on it.
    assign other_busy  = full_vec[~wbuf_reg] & ~(release_buf & (rbuf_reg == ~wbuf_reg));
    assign out_adv     = ~out_valid | out_ready;
    // The fetch address is a register; out_ready only gates the enables.
    assign fetch       = full_vec[fbuf_reg] & (~q_valid_reg | out_adv);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_W-1:0] mem [FRAME_LEN];
            logic [DATA_W-1:0] rd_q;
            logic              full_q;

            always_ff @(posedge clk) begin
                if (wr_en && wbuf_reg == 1'(gi))
                    mem[wptr_reg] <= wr_data;
                if (fetch && fbuf_reg == 1'(gi))
                    rd_q <= mem[fptr_reg];
            end

            assign full_set[gi] = wr_wrap & (wbuf_reg == 1'(gi));
            assign full_clr[gi] = release_buf & (rbuf_reg == 1'(gi));

            // Writer only completes into a non-full buffer and reader only releases a full one,
            // so set and clear never target the same buffer together.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    full_q <= 1'b0;
                else if (full_set[gi])
                    full_q <= 1'b1;
                else if (full_clr[gi])
                    full_q <= 1'b0;
            end

            assign full_vec[gi] = full_q;
            assign buf_q[gi]    = rd_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_reg <= W_FILL;
            wptr_reg     <= '0;
            wbuf_reg     <= 1'b0;
        end else begin
            if (wr_en)
                wptr_reg <= wptr_reg + 1'b1;
            if (wr_wrap) begin
                wbuf_reg     <= ~wbuf_reg;
                wr_state_reg <= other_busy ? W_STALL : W_FILL;
            end else if (!full_vec[wbuf_reg]) begin
                wr_state_reg <= W_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (clear_overrun) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    // Read pipeline: fetch stage (RAM read register) feeding the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fptr_reg    <= '0;
            fbuf_reg    <= 1'b0;
            rbuf_reg    <= 1'b0;
            q_valid_reg <= 1'b0;
            q_last_reg  <= 1'b0;
            q_buf_reg   <= 1'b0;
            q_index_reg <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
        end else begin
            if (out_adv) begin
                out_valid <= q_valid_reg;
                out_last  <= q_valid_reg & q_last_reg;
                if (q_valid_reg) begin
                    out_data  <= buf_q[q_buf_reg];
                    out_index <= q_index_reg;
                end
            end

            if (fetch) begin
                q_valid_reg <= 1'b1;
                q_index_reg <= fptr_reg;
                q_last_reg  <= (fptr_reg == LAST_IDX);
                q_buf_reg   <= fbuf_reg;
                fptr_reg    <= fptr_reg + 1'b1;
                if (fptr_reg == LAST_IDX)
                    fbuf_reg <= ~fbuf_reg;
            end else if (out_adv) begin
                q_valid_reg <= 1'b0;
            end

            if (release_buf)
                rbuf_reg <= ~rbuf_reg;
        end
    end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer (FRAME_LEN=8): a scoreboard queue of expected words is
// matched against every valid output cycle, plus flag/counter/latency checks.
module tb_sample_framer;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_sample = '0;
    logic        in_done = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_index;
    logic        out_last;
    logic        overrun;
    logic [15:0] drop_count;
    logic        clear_overrun = 1'b0;

    sample_framer #(.FRAME_LEN(FL), .DATA_W(16), .OFFSET_BIN(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_sample     (in_sample),
        .in_done       (in_done),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .out_last      (out_last),
        .overrun       (overrun),
        .drop_count    (drop_count),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic        prev_valid = 1'b0;
    int          rise_edge = -1;
    int          hs_cnt = 0;
    int          hs_first = -1;
    int          hs_last = -1;
    int          last_edge = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every valid cycle must show the oldest undelivered word; it stays put until accepted.
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (!prev_valid)
                rise_edge = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_word_q_depth", exp_q.size(), 1);
            end else begin
                chk("word", {12'h0, out_last, out_index, out_data}, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                    if (hs_first < 0)
                        hs_first = cyc + 1;
                    hs_last = cyc + 1;
                    if (out_last)
                        last_edge = cyc + 1;
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] s);
        in_sample = s;
        in_done   = 1'b1;
        tick();
        in_done   = 1'b0;
    endtask

    task automatic strobe_frame(input logic [15:0] base);
        for (int i = 0; i < FL; i++)
            strobe(base + 16'(i));
    endtask

    task automatic expect_frame(input logic [15:0] base);
        for (int i = 0; i < FL; i++)
            exp_q.push_back({12'h0, (i == FL - 1), 3'(i), base + 16'(i)});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_edge;
        int hs0;
        int n;

        // Reset values
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drops", drop_count, 0);
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Basic frame, sparse strobes, latency from 8th write
        out_ready = 1'b1;
        expect_frame(16'h0000);
        rise_edge = -1;
        for (int i = 0; i < FL; i++) begin
            strobe(16'h8000 + 16'(i));
            if (i < FL - 1) begin
                tick();
                tick();
            end
        end
        wr_edge = cyc;
        drain(40);
        chk("latency", rise_edge, wr_edge + 2);

        // Backpressure with pseudo-random ready
        hs0 = hs_cnt;
        expect_frame(16'h0010);
        for (int i = 0; i < FL; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            strobe(16'h8010 + 16'(i));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("bp_drain_left", exp_q.size(), 0);
        chk("bp_count", hs_cnt - hs0, 8);
        out_ready = 1'b1;
        tick();

        // Ping-pong, strobe every cycle, back-to-back frames
        hs_first = -1;
        expect_frame(16'h0100);
        expect_frame(16'h0108);
        for (int i = 0; i < 2 * FL; i++)
            strobe(16'h8100 + 16'(i));
        drain(60);
        chk("pp_span", hs_last - hs_first, 15);
        chk("pp_overrun", overrun, 0);

        // Overrun: 16 + 5 samples with the consumer stalled
        out_ready = 1'b0;
        expect_frame(16'h0200);
        expect_frame(16'h0208);
        for (int i = 0; i < 2 * FL + 5; i++)
            strobe(16'h8200 + 16'(i));
        chk("ovr_flag", overrun, 1);
        chk("ovr_drops", drop_count, 5);
        out_ready = 1'b1;
        strobe(16'h82FF);
        chk("ovr_drops_still_full", drop_count, 6);
        clear_overrun = 1'b1;
        strobe(16'h82FE);
        clear_overrun = 1'b0;
        chk("clr_wins_flag", overrun, 0);
        chk("clr_wins_drops", drop_count, 0);
        n = 0;
        while (exp_q.size() > FL && n < 40) begin
            tick();
            n++;
        end
        chk("ovr_first_freed", exp_q.size(), FL);
        expect_frame(16'h0300);
        strobe_frame(16'h8300);
        drain(60);
        chk("ovr_after_flag", overrun, 0);
        chk("ovr_after_drops", drop_count, 0);

        // Frame completes on the same edge the other buffer is released
        expect_frame(16'h0400);
        expect_frame(16'h0408);
        expect_frame(16'h0410);
        strobe_frame(16'h8400);
        tick();
        tick();
        strobe_frame(16'h8408);
        wr_edge = cyc;
        chk("sim_align", last_edge, wr_edge);
        strobe_frame(16'h8410);
        drain(80);
        chk("sim_drops", drop_count, 0);
        chk("sim_overrun", overrun, 0);

        // Reset mid-stream, with a partial frame also pending
        expect_frame(16'h0500);
        strobe_frame(16'h8500);
        for (int i = 0; i < 3; i++)
            strobe(16'h8600 + 16'(i));
        n = 0;
        while (!(out_valid && out_index == 3'd3) && n < 40) begin
            tick();
            n++;
        end
        chk("mid_index", 32'(out_index), 3);
        mon_en = 1'b0;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_index", out_index, 0);
        chk("mid_rst_last", out_last, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;
        rise_edge = -1;
        expect_frame(16'h0700);
        strobe_frame(16'h8700);
        wr_edge = cyc;
        drain(40);
        chk("post_rst_latency", rise_edge, wr_edge + 2);
        chk("post_rst_drops", drop_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
